// File: rtl/boundary_scan_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : boundary_scan_register_pkg
// Description : Shared chain-geometry constants, the per-cell operation type
//               and a chain-length helper for the boundary-scan register.
// Revision    : 1.0 - initial release
// ============================================================================
package boundary_scan_register_pkg;

    // Default pin-cell counts; the IDCODE/bypass paths size DR lengths from these
    localparam int c_DEFAULT_NUM_IN  = 4;
    localparam int c_DEFAULT_NUM_OUT = 4;

    // Chain bit nearest TDO
    localparam int c_TDO_BIT = 0;

    // Operation a cell performs on the next qualified TCK edge
    typedef enum logic [1:0] {
        BSR_HOLD    = 2'd0,
        BSR_CAPTURE = 2'd1,
        BSR_SHIFT   = 2'd2
    } bsr_op_e;

    // Total data-register length: input cells first (near TDO), then output cells
    function automatic int bsr_chain_len(input int num_in, input int num_out);
        return num_in + num_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsr_cell.sv
`default_nettype none
// ============================================================================
// Module      : bsr_cell
// Description : One boundary-scan cell: a capture/shift flop and, when
//               HAS_UPDATE is set, an update flop holding the pad value.
// Revision    : 1.0 - initial release
// ============================================================================
module bsr_cell
    import boundary_scan_register_pkg::*;
#(
    parameter bit HAS_UPDATE = 1'b0
) (
    input  logic i_tck,
    input  logic i_trst,
    input  logic i_capture_en,
    input  logic i_shift_en,
    input  logic i_update_en,
    input  logic i_capture_d,
    input  logic i_serial_in,
    output logic o_sr,
    output logic o_upd
);

    bsr_op_e w_op;
    logic    r_sr;

    // Capture outranks shift when the TAP asserts both
    always_comb begin
        w_op = BSR_HOLD;
        if (i_capture_en) begin
            w_op = BSR_CAPTURE;
        end else if (i_shift_en) begin
            w_op = BSR_SHIFT;
        end
    end

    // Capture/shift stage
    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_sr <= 1'b0;
        end else begin
            case (w_op)
                BSR_CAPTURE: r_sr <= i_capture_d;
                BSR_SHIFT:   r_sr <= i_serial_in;
                default:     r_sr <= r_sr;
            endcase
        end
    end

    assign o_sr = r_sr;

    generate
        if (HAS_UPDATE) begin : g_update
            logic r_upd;

            // Update stage latches the pre-edge shift value, independent of bsr_clk
            always_ff @(posedge i_tck or posedge i_trst) begin
                if (i_trst) begin
                    r_upd <= 1'b0;
                end else if (i_update_en) begin
                    r_upd <= r_sr;
                end
            end

            assign o_upd = r_upd;
        end else begin : g_no_update
            logic w_unused_update;
            assign w_unused_update = i_update_en;
            assign o_upd           = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/boundary_scan_register.sv
`default_nettype none
// ============================================================================
// Module      : boundary_scan_register
// Description : Boundary-scan data register chain for NUM_IN input pins and
//               NUM_OUT output pins; serves SAMPLE/PRELOAD and EXTEST and is
//               transparent in functional mode.
// Revision    : 1.0 - initial release
// ============================================================================
module boundary_scan_register
    import boundary_scan_register_pkg::*;
#(
    parameter int NUM_IN  = c_DEFAULT_NUM_IN,
    parameter int NUM_OUT = c_DEFAULT_NUM_OUT
) (
    input  logic               i_tck,
    input  logic               i_trst,
    input  logic               i_bsr_clk,
    input  logic               i_capture_dr,
    input  logic               i_shift_dr,
    input  logic               i_bsr_update,
    input  logic               i_extest,
    input  logic               i_bsr_tdi,
    output logic               o_bsr_tdo,
    input  logic [NUM_IN-1:0]  i_pin_in,
    output logic [NUM_IN-1:0]  o_core_in,
    input  logic [NUM_OUT-1:0] i_core_out,
    output logic [NUM_OUT-1:0] o_pin_out
);

    localparam int c_LEN = bsr_chain_len(NUM_IN, NUM_OUT);

    // A chain with no input or no output cells is not a supported build
    generate
        if (NUM_IN < 1 || NUM_OUT < 1) begin : g_bad_params
            $error("boundary_scan_register: NUM_IN and NUM_OUT must both be at least 1");
        end
    endgenerate

    logic               w_capture_en;
    logic               w_shift_en;
    logic [c_LEN-1:0]   w_capture_d;
    logic [c_LEN-1:0]   w_serial_in;
    logic [c_LEN-1:0]   w_sr;
    logic [NUM_OUT-1:0] w_upd;
    logic [NUM_IN-1:0]  w_unused_in_upd;

    assign w_capture_en = i_bsr_clk & i_capture_dr;
    assign w_shift_en   = i_bsr_clk & i_shift_dr;

    // Capture image: output cells sit above the input cells
    assign w_capture_d = {i_core_out, i_pin_in};

    // Each cell takes its serial input from the next cell up; TDI feeds the top
    assign w_serial_in = {i_bsr_tdi, w_sr[c_LEN-1:1]};

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in_cell
            bsr_cell #(
                .HAS_UPDATE (1'b0)
            ) u_cell (
                .i_tck        (i_tck),
                .i_trst       (i_trst),
                .i_capture_en (w_capture_en),
                .i_shift_en   (w_shift_en),
                .i_update_en  (i_bsr_update),
                .i_capture_d  (w_capture_d[gi]),
                .i_serial_in  (w_serial_in[gi]),
                .o_sr         (w_sr[gi]),
                .o_upd        (w_unused_in_upd[gi])
            );
        end

        for (genvar go = 0; go < NUM_OUT; go++) begin : g_out_cell
            bsr_cell #(
                .HAS_UPDATE (1'b1)
            ) u_cell (
                .i_tck        (i_tck),
                .i_trst       (i_trst),
                .i_capture_en (w_capture_en),
                .i_shift_en   (w_shift_en),
                .i_update_en  (i_bsr_update),
                .i_capture_d  (w_capture_d[NUM_IN+go]),
                .i_serial_in  (w_serial_in[NUM_IN+go]),
                .o_sr         (w_sr[NUM_IN+go]),
                .o_upd        (w_upd[go])
            );
        end
    endgenerate

    // Pad and core paths are combinational so an instruction change acts at once
    assign o_pin_out = i_extest ? w_upd : i_core_out;
    assign o_core_in = i_pin_in;
    assign o_bsr_tdo = w_sr[c_TDO_BIT];

endmodule
`default_nettype wire

// File: tb/tb_boundary_scan_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_boundary_scan_register
// Description : Scoreboard bench for boundary_scan_register (4 in / 4 out).
//               The reference holds the chain as a bit queue (front = TDO).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boundary_scan_register;

    localparam int NI = 4;
    localparam int NO = 4;

    logic          tck = 1'b0;
    logic          trst, bsr_clk, capture_dr, shift_dr, bsr_update, extest, bsr_tdi;
    logic [NI-1:0] pin_in;
    logic [NO-1:0] core_out;
    logic          bsr_tdo;
    logic [NI-1:0] core_in;
    logic [NO-1:0] pin_out;

    boundary_scan_register #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
        .i_tck        (tck),
        .i_trst       (trst),
        .i_bsr_clk    (bsr_clk),
        .i_capture_dr (capture_dr),
        .i_shift_dr   (shift_dr),
        .i_bsr_update (bsr_update),
        .i_extest     (extest),
        .i_bsr_tdi    (bsr_tdi),
        .o_bsr_tdo    (bsr_tdo),
        .i_pin_in     (pin_in),
        .o_core_in    (core_in),
        .i_core_out   (core_out),
        .o_pin_out    (pin_out)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic          tdo;
        logic [NO-1:0] pin_out;
        logic [NI-1:0] core_in;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   errors = 0;
    int   checks = 0;

    // Reference model: chain as a bit list, update stage as a plain vector
    bit            chain[$];
    logic [NO-1:0] upd_m;

    function automatic void model_reset();
        chain.delete();
        for (int i = 0; i < NI + NO; i++) chain.push_back(1'b0);
        upd_m = '0;
    endfunction

    function automatic void model_edge();
        logic [NO-1:0] nu;
        nu = upd_m;
        if (bsr_update) for (int j = 0; j < NO; j++) nu[j] = chain[NI + j];
        if (bsr_clk && capture_dr) begin
            chain.delete();
            for (int i = 0; i < NI; i++) chain.push_back(pin_in[i]);
            for (int j = 0; j < NO; j++) chain.push_back(core_out[j]);
        end else if (bsr_clk && shift_dr) begin
            void'(chain.pop_front());
            chain.push_back(bsr_tdi);
        end
        upd_m = nu;
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.tdo     = chain[0];
        e.pin_out = extest ? upd_m : core_out;
        e.core_in = pin_in;
        e.tag     = tag;
        exp_q.push_back(e);
    endfunction

    // Monitor: consumes expectations on each falling edge or on demand
    initial begin
        exp_t e;
        forever begin
            @(negedge tck or sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bsr_tdo !== e.tdo) begin
                    errors++;
                    $display("FAIL %s tdo: got %b want %b @%0t", e.tag, bsr_tdo, e.tdo, $time);
                end
                checks++;
                if (pin_out !== e.pin_out) begin
                    errors++;
                    $display("FAIL %s pin_out: got %h want %h @%0t", e.tag, pin_out, e.pin_out, $time);
                end
                checks++;
                if (core_in !== e.core_in) begin
                    errors++;
                    $display("FAIL %s core_in: got %h want %h @%0t", e.tag, core_in, e.core_in, $time);
                end
            end
        end
    end

    // One TCK cycle: drive inputs, step the model at the edge, expect after it
    task automatic cycle(input logic cap, input logic sh, input logic bclk, input logic upd,
                         input logic ext, input logic tdi, input logic [NI-1:0] pin,
                         input logic [NO-1:0] cout, input string tag);
        capture_dr = cap; shift_dr = sh; bsr_clk = bclk; bsr_update = upd;
        extest = ext; bsr_tdi = tdi; pin_in = pin; core_out = cout;
        @(posedge tck);
        model_edge();
        #1 push_exp(tag);
        @(negedge tck);
        #1;
    endtask

    // Asynchronous reset pulse with an immediate check before any clock edge
    task automatic async_reset(input string tag);
        trst = 1'b1;
        model_reset();
        #1 push_exp(tag);
        -> sample_ev;
        #1;
        @(negedge tck);
        #1 trst = 1'b0;
    endtask

    task automatic shift_word(input logic [7:0] w, input logic ext, input logic [NO-1:0] cout,
                              input string tag);
        for (int i = 0; i < NI + NO; i++) cycle(0, 1, 1, 0, ext, w[i], 4'h3, cout, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NO-1:0] co;
        // Reset with activity on the inputs
        trst = 1'b1; bsr_clk = 1; capture_dr = 0; shift_dr = 1; bsr_update = 1;
        extest = 0; bsr_tdi = 1; pin_in = 4'h6; core_out = 4'h9;
        model_reset();
        #1 push_exp("reset");
        -> sample_ev;
        @(negedge tck); #1 trst = 1'b0;

        // Capture A/5 then shift out 8 zeros: tdo 0,1,0,1,1,0,1,0 then zeros
        cycle(1, 0, 1, 0, 0, 0, 4'hA, 4'h5, "capture");
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0, 4'hA, 4'h5, "shift_out");

        // Preload C3, update, then EXTEST drives C regardless of core_out
        shift_word(8'hC3, 0, 4'h5, "preload");
        cycle(0, 0, 1, 1, 0, 0, 4'h3, 4'h5, "update");
        cycle(0, 0, 1, 0, 1, 0, 4'h3, 4'h5, "extest_on");
        cycle(0, 0, 1, 0, 1, 0, 4'h3, 4'hA, "extest_hold");
        cycle(0, 0, 1, 0, 1, 0, 4'h3, 4'h0, "extest_hold");

        // SAMPLE transparency with FF preloaded
        shift_word(8'hFF, 0, 4'h1, "sample_pre");
        cycle(0, 0, 1, 1, 0, 0, 4'h2, 4'h4, "sample_upd");
        for (int i = 0; i < 6; i++)
            cycle(0, 0, 1, 0, 0, 0, 4'($urandom), 4'($urandom), "sample_track");

        // Gating: shift_dr without bsr_clk holds, then capture beats shift
        cycle(1, 0, 1, 0, 0, 0, 4'h9, 4'h6, "gate_cap");
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 1, 4'h9, 4'h6, "gated");
        cycle(1, 1, 1, 0, 0, 1, 4'hE, 4'h7, "cap_priority");
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0, 4'hE, 4'h7, "prio_out");

        // Reset mid-shift under EXTEST with upd = C
        shift_word(8'hC3, 0, 4'h5, "preload2");
        cycle(0, 0, 1, 1, 1, 0, 4'h3, 4'h5, "update2");
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 1, 1, 4'h3, 4'h5, "mid_shift");
        async_reset("reset_mid_shift");
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 1, 0, 4'h3, 4'h5, "post_reset");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand_reset");
            end else begin
                co = 4'($urandom);
                cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) != 0, ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      4'($urandom), co, "random");
            end
        end

        @(negedge tck); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boundary_scan_register.md
# boundary_scan_register

Boundary-scan data register chain sitting directly downstream of the JTAG test logic. It consumes the test logic's `bsr_tdi`, `bsr_clk` and `bsr_update` together with the TAP capture/shift strobes, and returns `bsr_tdo`. It implements capture, shift and update cells for `NUM_IN` device input pins and `NUM_OUT` device output pins, serving the SAMPLE/PRELOAD and EXTEST instructions. In functional mode it is transparent: pins pass straight to and from the core.

## Interface
- `NUM_IN`, default 4: number of input-pin cells.
- `NUM_OUT`, default 4: number of output-pin cells. Chain length `L = NUM_IN + NUM_OUT`.
- `tck`  in  1: the only clock; all state updates on the rising edge.
- `trst`  in  1: reset, asynchronous, active-high; clears all state.
- `bsr_clk`  in  1: chain-access qualifier; high when the BSR is the selected data register and TCK is clocking the DR.
- `capture_dr`  in  1: TAP Capture-DR state.
- `shift_dr`  in  1: TAP Shift-DR state.
- `bsr_update`  in  1: one-cycle update strobe.
- `extest`  in  1: EXTEST instruction active.
- `bsr_tdi`  in  1: serial input.
- `bsr_tdo`  out  1: serial output, equal to `sr[0]`.
- `pin_in`  in  `NUM_IN`: values at the device input pads.
- `core_in`  out  `NUM_IN`: values delivered to the core; always equals `pin_in`.
- `core_out`  in  `NUM_OUT`: values the core drives toward the pads.
- `pin_out`  out  `NUM_OUT`: values at the output pads.

## Operation
- Shift stage `sr[L-1:0]`.
  - Bits `[NUM_IN-1:0]` are the input cells.
  - Bits `[L-1:NUM_IN]` are the output cells.
  - Bit 0 is nearest TDO.
- Update stage `upd[NUM_OUT-1:0]` exists for the output cells only.
- Per rising `tck`, evaluated in priority order:
  1. Capture, when `bsr_clk & capture_dr`: `sr <= {core_out, pin_in}`.
  2. Shift, when `bsr_clk & shift_dr`: `sr <= {bsr_tdi, sr[L-1:1]}`.
  3. Otherwise `sr` holds.
- Update, when `bsr_update`: `upd <= sr[L-1:NUM_IN]`. It is independent of `bsr_clk` and may coincide with capture or shift; it uses the pre-edge `sr`.
- `pin_out = extest ? upd : core_out`. This is combinational, so a mode change takes effect immediately.
- `core_in = pin_in`. There is no INTEST.
- `bsr_tdo = sr[0]`. It is combinational from the flop. Retiming to the falling TCK edge is owned by the test logic's TDO mux.
- SAMPLE/PRELOAD uses the same capture, shift and update path with `extest` low, so the pins are undisturbed.

## Timing
- Reset (`trst` high), asynchronous:
  - `sr = 0`, `upd = 0`, so `bsr_tdo = 0`.
  - `pin_out` is 0 if `extest` is high, otherwise `core_out`.
- Capture latency: 1 `tck` edge. The first captured bit (`pin_in[0]`) is on `bsr_tdo` immediately after that edge.
- Shift: each qualified edge moves `bsr_tdi` into `sr[L-1]`. A bit shifted in appears on `bsr_tdo` after L edges.
- Update latency: 1 edge from `bsr_update` to `upd`, and so to `pin_out` under EXTEST.
- Coincident `capture_dr` and `shift_dr`: capture wins.
- `bsr_clk` low: capture and shift are ignored; `sr` holds.
- Reset mid-shift: the partial contents are discarded and `upd` is cleared. After `trst` falls, operation resumes from zeros with no residual state.
- `NUM_IN` or `NUM_OUT` equal to 0 is not supported. Elaboration must fail via an assertion.

## Structure
- Sub-module `bsr_cell`: one capture/shift flop plus an optional update flop, selected by parameter `HAS_UPDATE`. Instantiate it in a generate loop, `NUM_IN` cells without update and `NUM_OUT` cells with update.
- The EXTEST/SAMPLE_PRELOAD instruction encodings come from the shared `defines.sv` (`D_EXTEST`, `D_SAMPLE_PRELOAD`).
  - The parent decodes them into `extest`; no new constants are added here.
  - Chain-length and ordering constants belong in the same shared file, so the IDCODE and bypass paths can reference the total DR lengths.

## Test plan
All scenarios use `NUM_IN=4`, `NUM_OUT=4`.
- Reset: `trst=1` mid-activity → `sr=0`, `upd=0`, `bsr_tdo=0`; with `extest=0`, `pin_out` follows `core_out=4'h9`.
- Capture then shift out: `pin_in=4'hA`, `core_out=4'h5`; capture with `bsr_clk=1`, then 8 shifts with `bsr_tdi=0` → `bsr_tdo` sequence 0,1,0,1,1,0,1,0 and final `sr=8'h00`.
- Preload and EXTEST: shift in `8'hC3` LSB first, pulse `bsr_update`, set `extest=1` → `pin_out=4'hC`; change `core_out` → `pin_out` stays `4'hC`.
- SAMPLE transparency: `extest=0`, full preload and update of `8'hFF` → `pin_out` tracks `core_out` every cycle and `core_in` tracks `pin_in`.
- Gating and priority: `shift_dr=1`, `bsr_clk=0` for 5 edges → `sr` unchanged. Then `capture_dr=shift_dr=1` with `bsr_clk=1` → `sr={core_out, pin_in}`.
- Reset mid-shift under EXTEST: `upd=4'hC`, `extest=1`, assert `trst` after 3 shifts → `pin_out=0` and `sr=0` immediately, asynchronously.
